cdb_arbiter: RTL

//  Writeback stage behind the ALU, branch and memory functional units.

---
 rtl/cdb_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: writeback stage behind the ALU, branch and memory units.
// Each unit's result is captured into its own SLOTS-deep unordered buffer.
// Every cycle the oldest buffered result (smallest distance from rob_head)
// is loaded into the CDB output register and its slot freed.
// A branch mispredict squashes buffered and arriving results younger than
// the mispredicted branch.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   {alu,br,mem}_valid/tag/pd/we/data   functional-unit results
//   rob_head                   oldest ROB tag, reference point for age
//   mispredict, mispredict_tag squash request and the branch's own tag
//   {alu,br,mem}_stall         registered "stop issuing" hints to the RS
//   cdb_valid/tag/pd/we/data/src   registered broadcast (src 0 ALU, 1 BR, 2 MEM)
//   overflow_err               sticky: a result arrived at a full buffer
module cdb_arbiter #(
  parameter int SLOTS        = 4,
  parameter int STALL_MARGIN = 2,
  parameter int TAG_W        = 5,
  parameter int PREG_W       = 7,
  parameter int XLEN         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic              alu_we,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [PREG_W-1:0] br_pd,
  input  logic              br_we,
  input  logic [XLEN-1:0]   br_data,
  input  logic              mem_valid,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [TAG_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              alu_stall,
  output logic              br_stall,
  output logic              mem_stall,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [PREG_W-1:0] cdb_pd,
  output logic              cdb_we,
  output logic [XLEN-1:0]   cdb_data,
  output logic [1:0]        cdb_src,
  output logic              overflow_err
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(SLOTS - STALL_MARGIN);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PREG_W-1:0] pd;
    logic              we;
    logic [XLEN-1:0]   data;
  } entry_t;

  // Distance from the ROB head; wraps modulo 2^TAG_W, smaller is older.
  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] t,
                                              input logic [TAG_W-1:0] head);
    return t - head;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < SLOTS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  entry_t           slot_r [0:2][0:SLOTS-1];
  logic [SLOTS-1:0] vld_r  [0:2];

  entry_t           in_ent_s   [0:2];
  logic [2:0]       in_vld_s;
  logic [SLOTS-1:0] live_s     [0:2];
  logic [SLOTS-1:0] keep_s     [0:2];
  logic [SLOTS-1:0] free_s     [0:2];
  logic [SLOTS-1:0] cap_oh_s   [0:2];
  logic [SLOTS-1:0] nxt_vld_s  [0:2];
  logic [CNT_W-1:0] occ_s      [0:2];
  logic [2:0]       cap_ok_s;
  logic             ovf_s;
  logic             sel_found_s;
  logic [1:0]       sel_fu_s;
  logic [IDX_W-1:0] sel_slot_s;
  logic [TAG_W-1:0] sel_age_s;
  entry_t           sel_ent_s;
  logic [TAG_W-1:0] mp_age_s;

  // Gather the three functional-unit inputs into indexable form.
  always_comb begin
    in_vld_s    = {mem_valid, br_valid, alu_valid};
    in_ent_s[0] = '{tag: alu_tag, pd: alu_pd, we: alu_we, data: alu_data};
    in_ent_s[1] = '{tag: br_tag,  pd: br_pd,  we: br_we,  data: br_data};
    in_ent_s[2] = '{tag: mem_tag, pd: mem_pd, we: mem_we, data: mem_data};
  end

  // Squash filter, oldest-first selection, and next-state slot bookkeeping.
  always_comb begin
    mp_age_s    = age_of(mispredict_tag, rob_head);
    sel_found_s = 1'b0;
    sel_fu_s    = 2'd0;
    sel_slot_s  = {IDX_W{1'b0}};
    sel_age_s   = {TAG_W{1'b1}};
    sel_ent_s   = '{tag: {TAG_W{1'b0}}, pd: {PREG_W{1'b0}}, we: 1'b0, data: {XLEN{1'b0}}};
    ovf_s       = 1'b0;
    for (int f = 0; f < 3; f++) begin
      // Squashed slots neither survive nor compete this cycle.
      for (int s = 0; s < SLOTS; s++) begin
        live_s[f][s] = vld_r[f][s] &
                       ~(mispredict && (age_of(slot_r[f][s].tag, rob_head) > mp_age_s));
      end
    end
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        logic better;
        better      = live_s[f][s] &&
                      (!sel_found_s || (age_of(slot_r[f][s].tag, rob_head) < sel_age_s));
        sel_found_s = sel_found_s | better;
        sel_fu_s    = better ? 2'(f) : sel_fu_s;
        sel_slot_s  = better ? IDX_W'(s) : sel_slot_s;
        sel_age_s   = better ? age_of(slot_r[f][s].tag, rob_head) : sel_age_s;
        sel_ent_s   = better ? slot_r[f][s] : sel_ent_s;
      end
    end
    for (int f = 0; f < 3; f++) begin
      // The slot being broadcast this edge is already free for capture.
      keep_s[f]   = live_s[f] &
                    ~((sel_found_s && (sel_fu_s == 2'(f)))
                      ? ({{(SLOTS-1){1'b0}}, 1'b1} << sel_slot_s)
                      : {SLOTS{1'b0}});
      free_s[f]   = ~keep_s[f];
      cap_ok_s[f] = in_vld_s[f] &&
                    !(mispredict && (age_of(in_ent_s[f].tag, rob_head) > mp_age_s));
      // Isolate the lowest set bit of the free mask.
      cap_oh_s[f]  = cap_ok_s[f] ? (free_s[f] & (~free_s[f] + {{(SLOTS-1){1'b0}}, 1'b1}))
                                 : {SLOTS{1'b0}};
      nxt_vld_s[f] = keep_s[f] | cap_oh_s[f];
      occ_s[f]     = popcount(nxt_vld_s[f]);
      ovf_s        = ovf_s | (cap_ok_s[f] && (free_s[f] == {SLOTS{1'b0}}));
    end
  end

  // Slot storage, broadcast register, stall hints and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int f = 0; f < 3; f++) vld_r[f] <= {SLOTS{1'b0}};
      cdb_valid    <= 1'b0;
      cdb_tag      <= {TAG_W{1'b0}};
      cdb_pd       <= {PREG_W{1'b0}};
      cdb_we       <= 1'b0;
      cdb_data     <= {XLEN{1'b0}};
      cdb_src      <= 2'd0;
      alu_stall    <= 1'b0;
      br_stall     <= 1'b0;
      mem_stall    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      for (int f = 0; f < 3; f++) begin
        vld_r[f] <= nxt_vld_s[f];
        for (int s = 0; s < SLOTS; s++) begin
          if (cap_oh_s[f][s]) slot_r[f][s] <= in_ent_s[f];
        end
      end
      cdb_valid    <= sel_found_s;
      cdb_tag      <= sel_found_s ? sel_ent_s.tag : {TAG_W{1'b0}};
      cdb_pd       <= sel_found_s ? sel_ent_s.pd : {PREG_W{1'b0}};
      cdb_we       <= sel_found_s & sel_ent_s.we;
      cdb_data     <= sel_found_s ? sel_ent_s.data : {XLEN{1'b0}};
      cdb_src      <= sel_found_s ? sel_fu_s : 2'd0;
      alu_stall    <= (occ_s[0] >= STALL_AT);
      br_stall     <= (occ_s[1] >= STALL_AT);
      mem_stall    <= (occ_s[2] >= STALL_AT);
      overflow_err <= overflow_err | ovf_s;
    end
  end

endmodule
